// File: rtl/context_switch_unit_pkg.sv
// Shared types and sizing for the context-switch unit and its context table.
package context_switch_unit_pkg;

    localparam int unsigned MAX_PROC = 5;
    localparam int unsigned PID_W    = 3;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned PC_W     = 32;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned IDX_W    = REG_AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAVE   = 2'd1,
        LOAD   = 2'd2,
        RESUME = 2'd3
    } csu_state_e;

    typedef logic [PID_W-1:0]  pid_t;
    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [WORD_W-1:0] word_t;

    function automatic logic pid_in_range(input pid_t pid);
        return pid < PID_W'(MAX_PROC);
    endfunction

endpackage

// File: rtl/context_switch_unit_if.sv
// Scheduler and core-side signals of the context-switch unit.
interface context_switch_unit_if;
    import context_switch_unit_pkg::*;

    logic              troca_contexto;
    pid_t              pid_entrada;
    pc_t               pc_atual;
    logic              criar_processo;
    pid_t              pid_novo;
    pc_t               pc_inicial;
    word_t             rf_rdata;
    logic [REG_AW-1:0] rf_addr;
    word_t             rf_wdata;
    logic              rf_we;
    pc_t               pc_out;
    logic              pc_load;
    logic              halt;
    pid_t              pid_executando;
    logic              erro;

    modport master (
        output troca_contexto, pid_entrada, pc_atual,
        output criar_processo, pid_novo, pc_inicial,
        output rf_rdata,
        input  rf_addr, rf_wdata, rf_we,
        input  pc_out, pc_load, halt, pid_executando, erro
    );

    modport slave (
        input  troca_contexto, pid_entrada, pc_atual,
        input  criar_processo, pid_novo, pc_inicial,
        input  rf_rdata,
        output rf_addr, rf_wdata, rf_we,
        output pc_out, pc_load, halt, pid_executando, erro
    );

endinterface

// File: rtl/context_switch_unit_context_table.sv
// Per-process saved registers, saved PC and the valid/first_run flags.
module context_table
    import context_switch_unit_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              ctx_we,
    input  pid_t              ctx_pid,
    input  logic [REG_AW-1:0] ctx_idx,
    input  word_t             ctx_wdata,
    input  logic              pc_we,
    input  pid_t              pc_pid,
    input  pc_t               pc_wdata,
    input  logic              create_we,
    input  pid_t              create_pid,
    input  pc_t               create_pc,
    input  logic              clr_first_we,
    input  pid_t              clr_pid,
    input  pid_t              rd_pid,
    input  logic [REG_AW-1:0] rd_idx,
    output word_t             rd_ctx_c,
    output pc_t               rd_pc_c,
    output logic              rd_first_run_c,
    output logic [MAX_PROC-1:0] valid
);

    word_t               ctx       [MAX_PROC][NUM_REGS];
    pc_t                 pc_mem    [MAX_PROC];
    logic [MAX_PROC-1:0] first_run;

    // Register save storage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < int'(MAX_PROC); p++) begin
                for (int r = 0; r < int'(NUM_REGS); r++) begin
                    ctx[p][r] <= '0;
                end
            end
        end else if (ctx_we) begin
            ctx[ctx_pid][ctx_idx] <= ctx_wdata;
        end
    end

    // Save and create never target the same pid in one cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < int'(MAX_PROC); p++) begin
                pc_mem[p] <= '0;
            end
        end else begin
            if (pc_we) begin
                pc_mem[pc_pid] <= pc_wdata;
            end
            if (create_we) begin
                pc_mem[create_pid] <= create_pc;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid     <= '0;
            first_run <= '0;
        end else begin
            if (clr_first_we) begin
                first_run[clr_pid] <= 1'b0;
            end
            if (create_we) begin
                valid[create_pid]     <= 1'b1;
                first_run[create_pid] <= 1'b1;
            end
        end
    end

    assign rd_ctx_c       = ctx[rd_pid][rd_idx];
    assign rd_pc_c        = pc_mem[rd_pid];
    assign rd_first_run_c = first_run[rd_pid];

endmodule

// File: rtl/context_switch_unit.sv
// Halts the core, saves the outgoing context, restores the incoming one
// and releases the core; also installs initial PCs for new processes.
module context_switch_unit
    import context_switch_unit_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    context_switch_unit_if.slave bus
);

    csu_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    pid_t              pid_in_q, pid_in_d;
    pid_t              pid_exec_q, pid_exec_d;
    pc_t               pc_sav_q, pc_sav_d;
    logic              running_q, running_d;

    logic              halt_q, halt_d;
    logic              rf_we_q, rf_we_d;
    logic              pc_load_q, pc_load_d;
    logic              erro_q, erro_d;
    word_t             rf_wdata_q, rf_wdata_d;
    pc_t               pc_out_q, pc_out_d;

    logic              create_ok, create_err, troca_err;
    logic              ctx_we, pc_we, clr_first;
    logic              last_idx, first_run_eff;
    word_t             rd_ctx_c;
    pc_t               rd_pc_c;
    logic              rd_first_run_c;
    logic [MAX_PROC-1:0] valid;

    context_table u_table (
        .clock          (clock),
        .reset          (reset),
        .ctx_we         (ctx_we),
        .ctx_pid        (pid_exec_q),
        .ctx_idx        (idx_q[REG_AW-1:0]),
        .ctx_wdata      (bus.rf_rdata),
        .pc_we          (pc_we),
        .pc_pid         (pid_exec_q),
        .pc_wdata       (pc_sav_q),
        .create_we      (create_ok),
        .create_pid     (bus.pid_novo),
        .create_pc      (bus.pc_inicial),
        .clr_first_we   (clr_first),
        .clr_pid        (pid_in_q),
        .rd_pid         (pid_in_d),
        .rd_idx         (idx_d[REG_AW-1:0]),
        .rd_ctx_c       (rd_ctx_c),
        .rd_pc_c        (rd_pc_c),
        .rd_first_run_c (rd_first_run_c),
        .valid          (valid)
    );

    assign last_idx = (idx_q == IDX_W'(NUM_REGS - 1));

    // A create may not touch the running process or the one being switched in
    always_comb begin
        create_ok  = 1'b0;
        create_err = 1'b0;
        if (bus.criar_processo) begin
            if (!pid_in_range(bus.pid_novo) ||
                (running_q && bus.pid_novo == pid_exec_q) ||
                (state_q != IDLE && bus.pid_novo == pid_in_q)) begin
                create_err = 1'b1;
            end else begin
                create_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pid_in_d   = pid_in_q;
        pid_exec_d = pid_exec_q;
        pc_sav_d   = pc_sav_q;
        running_d  = running_q;
        troca_err  = 1'b0;
        ctx_we     = 1'b0;
        pc_we      = 1'b0;
        clr_first  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.troca_contexto) begin
                    if (!pid_in_range(bus.pid_entrada)) begin
                        troca_err = 1'b1;
                    end else if (running_q && bus.pid_entrada == pid_exec_q) begin
                        troca_err = 1'b0;
                    end else if (!(valid[bus.pid_entrada] ||
                                   (create_ok && bus.pid_novo == bus.pid_entrada))) begin
                        troca_err = 1'b1;
                    end else begin
                        pid_in_d = bus.pid_entrada;
                        pc_sav_d = bus.pc_atual;
                        idx_d    = '0;
                        state_d  = running_q ? SAVE : LOAD;
                    end
                end
            end
            SAVE: begin
                ctx_we = 1'b1;
                pc_we  = (idx_q == '0);
                if (last_idx) begin
                    idx_d   = '0;
                    state_d = LOAD;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            LOAD: begin
                if (last_idx) begin
                    idx_d   = '0;
                    state_d = RESUME;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            RESUME: begin
                pid_exec_d = pid_in_q;
                running_d  = 1'b1;
                clr_first  = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && bus.troca_contexto) begin
            troca_err = 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with it;
    // a same-cycle create counts as first_run for the incoming pid.
    always_comb begin
        first_run_eff = rd_first_run_c || (create_ok && bus.pid_novo == pid_in_d);
        halt_d        = (state_d != IDLE);
        rf_we_d       = (state_d == LOAD);
        pc_load_d     = (state_d == RESUME);
        erro_d        = troca_err || create_err;
        rf_wdata_d    = '0;
        pc_out_d      = '0;
        if (state_d == LOAD && !first_run_eff) begin
            rf_wdata_d = rd_ctx_c;
        end
        if (state_d == RESUME) begin
            pc_out_d = rd_pc_c;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pid_in_q   <= '0;
            pid_exec_q <= '0;
            pc_sav_q   <= '0;
            running_q  <= 1'b0;
            halt_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            pc_load_q  <= 1'b0;
            erro_q     <= 1'b0;
            rf_wdata_q <= '0;
            pc_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pid_in_q   <= pid_in_d;
            pid_exec_q <= pid_exec_d;
            pc_sav_q   <= pc_sav_d;
            running_q  <= running_d;
            halt_q     <= halt_d;
            rf_we_q    <= rf_we_d;
            pc_load_q  <= pc_load_d;
            erro_q     <= erro_d;
            rf_wdata_q <= rf_wdata_d;
            pc_out_q   <= pc_out_d;
        end
    end

    assign bus.rf_addr        = idx_q[REG_AW-1:0];
    assign bus.rf_wdata       = rf_wdata_q;
    assign bus.rf_we          = rf_we_q;
    assign bus.pc_out         = pc_out_q;
    assign bus.pc_load        = pc_load_q;
    assign bus.halt           = halt_q;
    assign bus.pid_executando = pid_exec_q;
    assign bus.erro           = erro_q;

endmodule

// File: tb/tb_context_switch_unit.sv
// Randomized bench for context_switch_unit against a per-process context model.
module tb_context_switch_unit;
    import context_switch_unit_pkg::*;

    logic clock;
    logic reset;

    context_switch_unit_if bus();

    context_switch_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Core register file
    logic [31:0]       rf [NUM_REGS];
    logic              poke_en;
    logic [REG_AW-1:0] poke_addr;
    logic [31:0]       poke_data;

    assign bus.rf_rdata = rf[bus.rf_addr];

    always @(posedge clock) begin
        if (bus.rf_we) rf[bus.rf_addr] <= bus.rf_wdata;
        else if (poke_en) rf[poke_addr] <= poke_data;
    end

    // Reference model: what each process should own
    bit          m_valid [MAX_PROC];
    bit          m_first [MAX_PROC];
    logic [31:0] m_pc    [MAX_PROC];
    logic [31:0] m_ctx   [MAX_PROC][NUM_REGS];
    bit          m_rv;
    int          m_run;

    int checks;
    int errors;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < int'(MAX_PROC); p++) begin
            m_valid[p] = 1'b0;
            m_first[p] = 1'b0;
            m_pc[p]    = '0;
            for (int r = 0; r < int'(NUM_REGS); r++) m_ctx[p][r] = '0;
        end
        m_rv  = 1'b0;
        m_run = 0;
    endtask

    task automatic poke(input int a, input logic [31:0] d);
        poke_en   = 1'b1;
        poke_addr = REG_AW'(a);
        poke_data = d;
        @(posedge clock); #1;
        poke_en = 1'b0;
    endtask

    task automatic issue(input bit t, input int pe, input logic [31:0] pa,
                         input bit c, input int pn, input logic [31:0] pi,
                         input int inj_troca, input int inj_create, input int inj_reset);
        bit          c_ok, t_err, acc, pend_err;
        int          cnt, loads, writes, exp_len;
        logic [31:0] exp_pc;
        logic [31:0] snap   [NUM_REGS];
        logic [31:0] exp_rf [NUM_REGS];

        c_ok  = c && (pn < int'(MAX_PROC)) && !(m_rv && pn == m_run);
        t_err = 1'b0;
        acc   = 1'b0;
        if (t) begin
            if (pe >= int'(MAX_PROC)) t_err = 1'b1;
            else if (m_rv && pe == m_run) begin end
            else if (!(m_valid[pe] || (c_ok && pn == pe))) t_err = 1'b1;
            else acc = 1'b1;
        end
        if (c_ok) begin
            m_pc[pn]    = pi;
            m_valid[pn] = 1'b1;
            m_first[pn] = 1'b1;
        end
        for (int i = 0; i < int'(NUM_REGS); i++) snap[i] = rf[i];
        exp_len = 0;
        exp_pc  = '0;
        if (acc) begin
            exp_len = m_rv ? int'(2 * NUM_REGS + 1) : int'(NUM_REGS + 1);
            exp_pc  = m_pc[pe];
            for (int i = 0; i < int'(NUM_REGS); i++)
                exp_rf[i] = m_first[pe] ? 32'h0 : m_ctx[pe][i];
        end

        bus.troca_contexto = t;
        bus.pid_entrada    = PID_W'(pe);
        bus.pc_atual       = pa;
        bus.criar_processo = c;
        bus.pid_novo       = PID_W'(pn);
        bus.pc_inicial     = pi;
        @(posedge clock); #1;
        bus.troca_contexto = 1'b0;
        bus.criar_processo = 1'b0;
        check_eq("erro_req", 32'(bus.erro), 32'(t_err || (c && !c_ok)));
        check_eq("halt_start", 32'(bus.halt), 32'(acc));

        if (!acc) begin
            @(posedge clock); #1;
            check_eq("erro_one_cycle", 32'(bus.erro), 32'h0);
            check_eq("halt_idle", 32'(bus.halt), 32'h0);
            check_eq("pid_keep", 32'(bus.pid_executando), 32'(m_run));
            return;
        end

        cnt      = 1;
        loads    = 0;
        writes   = 0;
        pend_err = 1'b0;
        while (bus.halt && cnt < 200) begin
            if (bus.rf_we) writes++;
            if (bus.pc_load) begin
                loads++;
                check_eq("pc_out", bus.pc_out, exp_pc);
            end
            if (cnt == inj_reset) begin
                check_eq("rf_we_pre_reset", 32'(bus.rf_we), 32'h1);
                check_eq("rf_addr_pre_reset", 32'(bus.rf_addr),
                         32'(inj_reset - (m_rv ? int'(NUM_REGS + 1) : 1)));
                reset = 1'b0;
                #1;
                check_eq("halt_async_rst", 32'(bus.halt), 32'h0);
                check_eq("rf_we_async_rst", 32'(bus.rf_we), 32'h0);
                check_eq("pc_load_async_rst", 32'(bus.pc_load), 32'h0);
                repeat (2) @(posedge clock);
                #1;
                reset = 1'b1;
                model_reset();
                check_eq("pid_after_rst", 32'(bus.pid_executando), 32'h0);
                return;
            end
            if (cnt == inj_troca) begin
                bus.troca_contexto = 1'b1;
                bus.pid_entrada    = PID_W'($urandom_range(0, 7));
                pend_err = 1'b1;
            end
            if (cnt == inj_create) begin
                bus.criar_processo = 1'b1;
                bus.pid_novo       = PID_W'(pe);
                bus.pc_inicial     = $urandom;
                pend_err = 1'b1;
            end
            @(posedge clock); #1;
            bus.troca_contexto = 1'b0;
            bus.criar_processo = 1'b0;
            if (pend_err) begin
                check_eq("erro_busy", 32'(bus.erro), 32'h1);
                pend_err = 1'b0;
            end
            if (bus.halt) cnt++;
        end

        check_eq("halt_len", 32'(cnt), 32'(exp_len));
        check_eq("pc_load_count", 32'(loads), 32'h1);
        check_eq("rf_write_count", 32'(writes), 32'(NUM_REGS));
        check_eq("pid_exec", 32'(bus.pid_executando), 32'(pe));

        if (m_rv) begin
            for (int i = 0; i < int'(NUM_REGS); i++) m_ctx[m_run][i] = snap[i];
            m_pc[m_run] = pa;
        end
        m_run      = pe;
        m_rv       = 1'b1;
        m_first[pe] = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) check_eq("rf_restore", rf[i], exp_rf[i]);
    endtask

    int op, pe, pn, p;
    bit cc;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        poke_en = 1'b0;
        poke_addr = '0;
        poke_data = '0;
        bus.troca_contexto = 1'b0;
        bus.pid_entrada    = '0;
        bus.pc_atual       = '0;
        bus.criar_processo = 1'b0;
        bus.pid_novo       = '0;
        bus.pc_inicial     = '0;
        model_reset();
        @(posedge clock); #1;
        for (int i = 0; i < int'(NUM_REGS); i++) poke(i, $urandom);

        check_eq("rst_halt", 32'(bus.halt), 32'h0);
        check_eq("rst_erro", 32'(bus.erro), 32'h0);
        check_eq("rst_pc_load", 32'(bus.pc_load), 32'h0);
        check_eq("rst_rf_we", 32'(bus.rf_we), 32'h0);
        check_eq("rst_pc_out", bus.pc_out, 32'h0);
        check_eq("rst_pid", 32'(bus.pid_executando), 32'h0);
        reset = 1'b1;
        @(posedge clock); #1;

        // First switch after reset: no save phase
        issue(1'b0, 0, 32'h0, 1'b1, 0, 32'h100, -1, -1, -1);
        issue(1'b1, 0, 32'h0, 1'b0, 0, 32'h0, -1, -1, -1);

        // Full save/restore round trip
        poke(5, 32'hAAAA);
        issue(1'b0, 0, 32'h0, 1'b1, 1, 32'h200, -1, -1, -1);
        issue(1'b1, 1, 32'h140, 1'b0, 0, 32'h0, -1, -1, -1);
        issue(1'b1, 0, 32'h220, 1'b0, 0, 32'h0, -1, -1, -1);
        check_eq("rf5_restored", rf[5], 32'hAAAA);

        // Rejections and the ignored self-switch
        issue(1'b1, 4, 32'h0, 1'b0, 0, 32'h0, -1, -1, -1);
        issue(1'b1, 6, 32'h0, 1'b0, 0, 32'h0, -1, -1, -1);
        issue(1'b1, 0, 32'h0, 1'b0, 0, 32'h0, -1, -1, -1);

        // Busy-time troca in LOAD and create of pid_in in SAVE
        issue(1'b0, 0, 32'h0, 1'b1, 2, 32'h300, -1, -1, -1);
        issue(1'b1, 2, 32'h330, 1'b0, 0, 32'h0, 40, 5, -1);

        for (int k = 0; k < 40; k++) begin
            op = int'($urandom_range(0, 9));
            if (op < 3) begin
                issue(1'b0, 0, 32'h0, 1'b1, int'($urandom_range(0, 7)), $urandom, -1, -1, -1);
            end else begin
                repeat ($urandom_range(0, 4)) poke(int'($urandom_range(0, 31)), $urandom);
                pe = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7))
                                                 : int'($urandom_range(0, MAX_PROC - 1));
                cc = ($urandom_range(0, 3) == 0);
                pn = ($urandom_range(0, 1) == 1) ? pe : int'($urandom_range(0, 7));
                issue(1'b1, pe, $urandom, cc, pn, $urandom, -1, -1, -1);
            end
        end

        // Reset in the middle of LOAD at idx 10
        p = (m_run + 1) % int'(MAX_PROC);
        issue(1'b0, 0, 32'h0, 1'b1, p, 32'h400, -1, -1, -1);
        issue(1'b1, p, 32'h440, 1'b0, 0, 32'h0, -1, -1,
              m_rv ? int'(NUM_REGS + 11) : 11);

        // All processes invalid after reset; same-cycle create+switch is accepted
        issue(1'b1, 0, 32'h0, 1'b0, 0, 32'h0, -1, -1, -1);
        issue(1'b1, 1, 32'h500, 1'b1, 1, 32'h600, -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
